// File: rtl/crc_frame_tx.sv
// Serialises a DATA_LENGTH-bit payload MSB-first followed by its 16-bit CRC
// (x^16+x^15+x^2+1, init 16'hFFFF, no final xor), with valid/ready on both sides.
//
//   state | meaning
//   IDLE  | waiting for a payload word; in_ready high
//   DATA  | presenting payload bits, CRC register accumulating
//   CRC   | presenting the 16 CRC bits, MSB first
module crc_frame_tx #(
  parameter int DATA_LENGTH = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_LENGTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_bit,
  output logic                   out_first,
  output logic                   out_last,
  output logic [15:0]            crc,
  output logic                   done
);

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_LENGTH);
  localparam logic [CNT_W-1:0] CNT_CRC  = CNT_W'(16);

  typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;

  state_t                 state_q;
  logic [DATA_LENGTH-1:0] shift_q, shift_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [15:0]            crc_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   in_ready_q, out_valid_q, out_bit_q;
  logic                   out_first_q, out_last_q, done_q;
  logic                   fb;
  logic                   xfer;

  assign xfer = out_valid_q && out_ready;

  always_comb begin
    fb      = lfsr_q[15] ^ out_bit_q;
    lfsr_d  = {lfsr_q[14] ^ fb, lfsr_q[13:2], lfsr_q[1] ^ fb, lfsr_q[0], fb};
    shift_d = shift_q << 1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      lfsr_q      <= 16'hFFFF;
      crc_q       <= 16'hFFFF;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q     <= DATA;
            shift_q     <= in_data;
            lfsr_q      <= 16'hFFFF;
            crc_q       <= 16'hFFFF;
            cnt_q       <= CNT_DATA;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_bit_q   <= in_data[DATA_LENGTH-1];
            out_first_q <= 1'b1;
            out_last_q  <= 1'b0;
          end
        end
        DATA: begin
          if (xfer) begin
            lfsr_q      <= lfsr_d;
            crc_q       <= lfsr_d;
            out_first_q <= 1'b0;
            if (cnt_q == CNT_W'(1)) begin
              // crc_q now freezes as the snapshot while lfsr_q is shifted out
              state_q   <= CRC;
              cnt_q     <= CNT_CRC;
              out_bit_q <= lfsr_d[15];
            end else begin
              cnt_q     <= cnt_q - CNT_W'(1);
              shift_q   <= shift_d;
              out_bit_q <= shift_d[DATA_LENGTH-1];
            end
          end
        end
        CRC: begin
          if (xfer) begin
            lfsr_q <= {lfsr_q[14:0], 1'b0};
            if (cnt_q == CNT_W'(1)) begin
              state_q     <= IDLE;
              cnt_q       <= '0;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_bit_q   <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              cnt_q      <= cnt_q - CNT_W'(1);
              out_bit_q  <= lfsr_q[14];
              out_last_q <= (cnt_q == CNT_W'(2));
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign crc       = crc_q;
  assign done      = done_q;

endmodule

// File: tb/tb_crc_frame_tx.sv
// Scoreboard bench for crc_frame_tx: stimulus pushes expected frame bits and CRCs,
// a negedge monitor pops and compares whenever a bit is transferred or done pulses.
module tb_crc_frame_tx;
  localparam int DL = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [DL-1:0] in_data = '0;
  logic          out_ready = 1'b1;
  logic          in_ready, out_valid, out_bit, out_first, out_last, done;
  logic [15:0]   crc;

  int checks = 0;
  int errs = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;
  bit bp_mode = 1'b0;
  logic [15:0] res = 16'hFFFF;
  logic last_prev = 1'b0;

  typedef struct packed {logic b; logic f; logic l;} exp_t;
  exp_t        bq[$];
  logic [15:0] cq[$];
  exp_t        e;

  crc_frame_tx #(.DATA_LENGTH(DL)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_first(out_first), .out_last(out_last), .crc(crc), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Bit-serial polynomial form: shift left, xor 0x8005 when feedback is set
  function automatic logic [15:0] step(input logic [15:0] r, input logic d);
    logic f;
    f = r[15] ^ d;
    return {r[14:0], 1'b0} ^ (f ? 16'h8005 : 16'h0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (done) begin
        done_cnt++;
        chk("done_after_last", last_prev, 1'b1);
        if (cq.size() == 0) begin
          checks++; errs++;
          $display("FAIL crc_unexpected_done: got done expected none at %0t", $time);
        end else chk("crc_final", crc, cq.pop_front());
      end
      if (out_valid) chk("in_ready_busy", in_ready, 1'b0);
      last_prev = out_valid && out_ready && out_last;
      if (out_valid && out_ready) begin
        if (bq.size() == 0) begin
          checks++; errs++;
          $display("FAIL bit_unexpected: got bit %b expected none at %0t", out_bit, $time);
        end else begin
          e = bq.pop_front();
          chk("bit", out_bit, e.b);
          chk("first", out_first, e.f);
          chk("last", out_last, e.l);
        end
        if (out_first) res = 16'hFFFF;
        res = step(res, out_bit);
        xfer_cnt++;
        if (out_last) chk("residue", res, 16'h0000);
      end
    end
  end

  task automatic push_frame(input logic [DL-1:0] w);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int i = DL - 1; i >= 0; i--) begin
      bq.push_back('{b: w[i], f: (i == DL - 1), l: 1'b0});
      r = step(r, w[i]);
    end
    for (int i = 15; i >= 0; i--) bq.push_back('{b: r[i], f: 1'b0, l: (i == 0)});
    cq.push_back(r);
  endtask

  task automatic offer(input logic [DL-1:0] w);
    bit ok;
    ok = 1'b0;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = w;
    for (int k = 0; k < 200; k++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    chk("accept_timeout", ok, 1'b1);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clock);
      #1;
      if (done_cnt >= target) begin ok = 1'b1; break; end
    end
    chk("done_timeout", ok, 1'b1);
  endtask

  task automatic run_frame(input logic [DL-1:0] w, input int target);
    xfer_cnt = 0;
    push_frame(w);
    offer(w);
    wait_done(target);
    chk("frame_len", xfer_cnt, DL + 16);
  endtask

  initial begin
    int d0;
    bit ok;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_crc", crc, 16'hFFFF);
    chk("rst_done", done, 1'b0);
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_crc", crc, 16'hFFFF);
    chk("idle_done", done, 1'b0);

    run_frame(32'hA5A5_0F0F, 1);
    @(negedge clock);
    #1 chk("done_one_cycle", done, 1'b0);

    bp_mode = 1'b1;
    run_frame(32'hA5A5_0F0F, 2);
    bp_mode = 1'b0;

    run_frame(32'h0000_0000, 3);
    run_frame(32'hFFFF_FFFF, 4);

    // back-to-back with in_valid held high
    push_frame(32'h1234_5678);
    push_frame(32'h9ABC_DEF0);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    chk("b2b_accept1", ok, 1'b1);
    @(posedge clock);
    #1 in_data = 32'h9ABC_DEF0;
    wait_done(5);
    chk("b2b_ready_at_done", in_ready, 1'b1);
    @(negedge clock);
    #1;
    chk("b2b_second_valid", out_valid, 1'b1);
    chk("b2b_second_first", out_first, 1'b1);
    in_valid = 1'b0;
    wait_done(6);

    // abort mid-frame after the 20th transfer
    xfer_cnt = 0;
    push_frame(32'hC3C3_5A5A);
    offer(32'hC3C3_5A5A);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (xfer_cnt >= 20) begin ok = 1'b1; break; end
      @(negedge clock);
      #1;
    end
    chk("abort_reach20", ok, 1'b1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    bq.delete();
    cq.delete();
    d0 = done_cnt;
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_bit", out_bit, 1'b0);
    chk("abort_first", out_first, 1'b0);
    chk("abort_last", out_last, 1'b0);
    chk("abort_crc", crc, 16'hFFFF);
    chk("abort_done", done, 1'b0);
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (3) @(negedge clock);
    #1 chk("abort_no_done", done_cnt, d0);
    run_frame(32'h0F1E_2D3C, d0 + 1);

    repeat (5) @(negedge clock);
    chk("queue_empty", bq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before limit");
    $fatal(1, "watchdog");
  end

endmodule
